wave_unit_arbiter: RTL and testbench

- Shares one pipelined float32 waveform unit (sawtooth_wave class: clk, x_in[31:0], y_out[31:0]) between N requesters.
- Round-robin grant, at most one issue per cycle, so throughput is 1 sample/cycle.
- Tracks each issued sample's owner through a tag pipeline and routes the result back to that requester.
- Sits between the per-channel waveform generators and the shared function unit.

---
 rtl/wave_unit_arbiter.sv | 142 ++++++++++++++
 tb/tb_wave_unit_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_unit_arbiter.sv
// wave_unit_arbiter
// Shares one pipelined float32 waveform unit between N requesters.
// Round-robin grant (one issue per cycle), a tag pipeline that follows each
// issued sample through the datapath, and a registered response that is
// routed back to the requester that issued it.
// Optional feature: define WAVE_ARB_STATS_EN to add saturating per-requester
// grant counters on the grant_cnt output.
module wave_unit_arbiter #(
  parameter int N      = 4,
  parameter int DP_LAT = 1,
  parameter int TW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_x,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       dp_x_in,
  input  logic [31:0]       dp_y_out,
  output logic [N-1:0]      rsp_valid,
  output logic [31:0]       rsp_y,
  output logic [TW:0]       in_flight,
`ifdef WAVE_ARB_STATS_EN
  output logic [16*N-1:0]   grant_cnt,
`endif
  output logic              idle
);

  // One tag stage per datapath edge plus the stage that lines up with dp_y_out.
  localparam int NS = DP_LAT + 1;

  logic [TW-1:0]         ptr_q, ptr_d;
  logic [31:0]           dp_x_q, dp_x_d;
  logic [NS-1:0]         tag_vld_q;
  logic [NS-1:0][TW-1:0] tag_idx_q;
  logic [N-1:0]          rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_y_q, rsp_y_d;
  logic [TW:0]           in_flight_q, in_flight_d;

  logic [N-1:0]          cand;
  logic                  grant_vld;
  logic [TW-1:0]         grant_idx;
  logic [31:0]           grant_x;
  logic [N-1:0]          grant_oh;
  logic                  ret_vld;
  logic [TW-1:0]         ret_idx;

  // Requests only count while granting is allowed and reset is released.
  assign cand = (enable && rst_n) ? req_valid : '0;

  // Rotating-priority search starting one past the last granted requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_x   = '0;
    grant_oh  = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!grant_vld && cand[j]) begin
        grant_vld   = 1'b1;
        grant_idx   = j[TW-1:0];
        grant_x     = req_x[32*j +: 32];
        grant_oh[j] = 1'b1;
      end
    end
  end

  assign ret_vld = tag_vld_q[NS-1];
  assign ret_idx = tag_idx_q[NS-1];

  // Next-state for the issue register, pointer, response and occupancy count.
  always_comb begin
    dp_x_d      = grant_vld ? grant_x : dp_x_q;
    ptr_d       = grant_vld ? grant_idx : ptr_q;
    rsp_y_d     = ret_vld ? dp_y_out : rsp_y_q;
    rsp_valid_d = '0;
    for (int i = 0; i < N; i++) begin
      rsp_valid_d[i] = ret_vld && (ret_idx == TW'(i));
    end
    in_flight_d = in_flight_q;
    if (grant_vld && !ret_vld) begin
      in_flight_d = in_flight_q + 1'b1;
    end else if (!grant_vld && ret_vld) begin
      in_flight_d = in_flight_q - 1'b1;
    end
  end

  // State registers; the tag pipeline advances every cycle with no stall path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= TW'(N - 1);
      dp_x_q      <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      in_flight_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      dp_x_q       <= dp_x_d;
      tag_vld_q[0] <= grant_vld;
      tag_idx_q[0] <= grant_idx;
      for (int s = 1; s < NS; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
      rsp_valid_q  <= rsp_valid_d;
      rsp_y_q      <= rsp_y_d;
      in_flight_q  <= in_flight_d;
    end
  end

`ifdef WAVE_ARB_STATS_EN
  logic [N-1:0][15:0] cnt_q;

  // Saturating accept counters, one per requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant_oh[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

  assign req_ready = grant_oh;
  assign dp_x_in   = dp_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0) && !(|req_valid);

endmodule

// File: tb/tb_wave_unit_arbiter.sv
// Bench for wave_unit_arbiter: table of per-cycle grant vectors plus a
// response scoreboard keyed on owner, value and return edge.
module tb_wave_unit_arbiter;

  localparam int N  = 4;
  localparam int TW = 3;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_x;
  logic [N-1:0]      req_ready;
  logic [31:0]       dp_x_in;
  logic [31:0]       dp_y_out;
  logic [N-1:0]      rsp_valid;
  logic [31:0]       rsp_y;
  logic [TW:0]       in_flight;
  logic              idle;
`ifdef WAVE_ARB_STATS_EN
  logic [16*N-1:0]   grant_cnt;
`endif

  wave_unit_arbiter #(.N(N), .DP_LAT(1), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .dp_x_in   (dp_x_in),
    .dp_y_out  (dp_y_out),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .in_flight (in_flight),
`ifdef WAVE_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .idle      (idle)
  );

  typedef struct {
    bit           rst_n;
    bit           en;
    logic [3:0]   valid;
    logic [3:0]   exp_ready;
    logic [127:0] x;
  } vec_t;

  typedef struct {
    logic [3:0]  oh;
    logic [31:0] y;
    int          due;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   edge_n  = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  localparam logic [127:0] X_ALL = {32'h3F000000, 32'hBFA00000, 32'h3F000000, 32'h3F000000};
  localparam logic [127:0] X_ONE = {32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40200000};
  localparam logic [127:0] X_MIX = {32'h7F800000, 32'h7FC00001, 32'h12345678, 32'hC0490FDB};

  // Sawtooth frac(x) for the operands used here; other values get a fixed scramble.
  function automatic logic [31:0] saw(input logic [31:0] x);
    case (x)
      32'h40200000: saw = 32'h3F000000;
      32'hBFA00000: saw = 32'h3F400000;
      32'h3F000000: saw = 32'h3F000000;
      32'h7FC00001: saw = 32'h7FC00001;
      32'h7F800000: saw = 32'h7FC00000;
      default:      saw = x ^ 32'h0055AA00;
    endcase
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    oh2i = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) oh2i = i;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic void add(input bit r, input bit e, input logic [3:0] v,
                              input logic [3:0] ex, input logic [127:0] x);
    vec_t t;
    t.rst_n = r; t.en = e; t.valid = v; t.exp_ready = ex; t.x = x;
    tbl.push_back(t);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Stand-in for the shared one-stage sawtooth unit.
  initial dp_y_out = '0;
  always @(posedge clk) dp_y_out <= saw(dp_x_in);

  // Response monitor.
  always @(negedge clk) begin
    sb_t e;
    if (rsp_valid !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(e.oh));
        chk("rsp_y", rsp_y, e.y);
        chk("rsp_latency", 32'(edge_n), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= edge_n) begin
      e = sb.pop_front();
      chk("rsp_missing", 32'(rsp_valid), 32'(e.oh));
    end
  end

  task automatic apply(input vec_t t);
    sb_t e;
    int  idx;
    @(negedge clk);
    rst_n     = t.rst_n;
    enable    = t.en;
    req_valid = t.valid;
    req_x     = t.x;
    #1;
    chk("in_flight", 32'(in_flight), 32'(sb.size()));
    chk("idle", 32'(idle), 32'((sb.size() == 0) && (t.valid == 4'b0000)));
    chk("req_ready", 32'(req_ready), 32'(t.exp_ready));
    if (!t.rst_n) begin
      sb.delete();
    end else if (t.exp_ready != 4'b0000) begin
      idx   = oh2i(t.exp_ready);
      e.oh  = t.exp_ready;
      e.y   = saw(t.x[32*idx +: 32]);
      e.due = edge_n + 3;
      sb.push_back(e);
    end
  endtask

  task automatic step(input bit r, input bit en, input logic [3:0] v,
                      input logic [3:0] ex, input logic [127:0] x);
    vec_t t;
    t.rst_n = r; t.en = en; t.valid = v; t.exp_ready = ex; t.x = x;
    apply(t);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'b1111;
    req_x     = X_ALL;

    // Reset held for three edges with every requester asking.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1111, 4'b0000, X_ALL);
    chk("reset_dp_x_in", dp_x_in, 32'h0);
    chk("reset_rsp_y", rsp_y, 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);

    // Mid-flight reset: accept on requester 0, reset on the next edge.
    step(1'b1, 1'b1, 4'b0001, 4'b0001, X_ONE);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, X_ONE);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000, 4'b0000, X_ONE);
    chk("midreset_dp_x_in", dp_x_in, 32'h0);

    // Round-robin burst, pointer restarts at N-1 after reset.
    add(1, 1, 4'b1111, 4'b0001, X_ALL);
    add(1, 1, 4'b1111, 4'b0010, X_ALL);
    add(1, 1, 4'b1111, 4'b0100, X_ALL);
    add(1, 1, 4'b1111, 4'b1000, X_ALL);
    add(1, 1, 4'b1111, 4'b0001, X_ALL);
    add(1, 1, 4'b1111, 4'b0010, X_ALL);
    add(1, 1, 4'b1111, 4'b0100, X_ALL);
    add(1, 1, 4'b1111, 4'b1000, X_ALL);
    for (int i = 0; i < 3; i++) add(1, 1, 4'b0000, 4'b0000, X_ALL);
    // Single request on requester 0 (2.5 -> 0.5).
    add(1, 1, 4'b0001, 4'b0001, X_ONE);
    for (int i = 0; i < 3; i++) add(1, 1, 4'b0000, 4'b0000, X_ONE);
    // Enable dropped mid-burst for three cycles.
    add(1, 1, 4'b1111, 4'b0010, X_ALL);
    add(1, 1, 4'b1111, 4'b0100, X_ALL);
    add(1, 0, 4'b1111, 4'b0000, X_ALL);
    add(1, 0, 4'b1111, 4'b0000, X_ALL);
    add(1, 0, 4'b1111, 4'b0000, X_ALL);
    add(1, 1, 4'b1111, 4'b1000, X_ALL);
    add(1, 1, 4'b1111, 4'b0001, X_ALL);
    for (int i = 0; i < 3; i++) add(1, 1, 4'b0000, 4'b0000, X_ALL);
    // Sparse request patterns with NaN/Inf operands.
    add(1, 1, 4'b1010, 4'b0010, X_MIX);
    add(1, 1, 4'b1010, 4'b1000, X_MIX);
    add(1, 1, 4'b0011, 4'b0001, X_MIX);
    add(1, 1, 4'b0110, 4'b0010, X_MIX);
    add(1, 1, 4'b0100, 4'b0100, X_MIX);
    add(1, 1, 4'b1001, 4'b1000, X_MIX);
    add(1, 0, 4'b1111, 4'b0000, X_MIX);
    add(1, 1, 4'b1100, 4'b0100, X_MIX);
    for (int i = 0; i < 3; i++) add(1, 1, 4'b0000, 4'b0000, X_MIX);

    for (int v = 0; v < tbl.size(); v++) apply(tbl[v]);

`ifdef WAVE_ARB_STATS_EN
    step(1'b0, 1'b1, 4'b0000, 4'b0000, X_ALL);
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, 4'b0010, 4'b0010, X_ALL);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000, 4'b0000, X_ALL);
    chk("grant_cnt1_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
    chk("grant_cnt0", 32'(grant_cnt[15:0]), 32'h0);
    chk("grant_cnt2", 32'(grant_cnt[47:32]), 32'h0);
    chk("grant_cnt3", 32'(grant_cnt[63:48]), 32'h0);
`endif

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
